// File: rtl/count_snapshot_fifo.sv
// count_snapshot_fifo
//
// Captures snapshots of an upstream free-running counter into a small
// first-word-fall-through FIFO. Each stored entry carries the captured
// count and a flag that says whether the counter wrapped (all-ones -> 0)
// at least once since the previous accepted capture.
//
// Parameters:
//   DEPTH  number of snapshot entries (power of two, 2..16)
//   CW     counter width (2..16)
//
// Ports:
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset
//   count_in   free-running count from the upstream counter
//   trig       capture request, sampled each rising edge
//   ovf_clr    clears the sticky overflow flag
//   out_ready  consumer ready; a pop happens when out_valid && out_ready
//   out_valid  head entry is valid (== !empty)
//   out_data   captured count of the head entry (0 when empty)
//   out_wrap   wrap flag of the head entry (0 when empty)
//   level      number of stored entries
//   full       level == DEPTH
//   empty      level == 0
//   overflow   sticky flag, set when a trigger is dropped on a full FIFO
module count_snapshot_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CW-1:0]            count_in,
  input  logic                     trig,
  input  logic                     ovf_clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [CW-1:0]            out_data,
  output logic                     out_wrap,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [CW-1:0]    data_mem [DEPTH];
  logic [DEPTH-1:0] wrap_mem;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    prev_count;
  logic             wrap_seen;

  logic             wrap_now;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // Status flags are pure decodes of level so they can never disagree.
  assign empty     = (level == '0);
  assign full      = (level == DEPTH_L);
  assign out_valid = !empty;

  // The head is gated by out_valid so that an empty FIFO (including the
  // reset state) always presents zeros, never stale pre-reset entries.
  assign out_data  = out_valid ? data_mem[rd_ptr] : '0;
  assign out_wrap  = out_valid ? wrap_mem[rd_ptr] : 1'b0;

  assign wrap_now  = (prev_count == {CW{1'b1}}) && (count_in == '0);

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop       = out_valid && out_ready;
  assign push_ok   = !rst && trig && (!full || pop);
  assign drop      = !rst && trig && full && !pop;

  // Storage array is not reset: the pointers and level decide what is
  // visible, and out_* are masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      data_mem[wr_ptr] <= count_in;
      wrap_mem[wr_ptr] <= wrap_seen | wrap_now;
    end
  end

  // Control state: pointers, occupancy, wrap tracking and overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      wrap_seen  <= 1'b0;
      prev_count <= '0;
    end else begin
      prev_count <= count_in;

      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      // A wrap seen on the capture edge itself is folded into the stored
      // entry, so the tracker restarts from zero after every accepted push.
      if (push_ok) begin
        wrap_seen <= 1'b0;
      end else begin
        wrap_seen <= wrap_seen | wrap_now;
      end

      // Setting wins over clearing so a drop is never lost.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // A stalled head must not change until it is consumed. The !out_valid
  // escape covers an asynchronous reset pulse landing between two edges.
  a_head_stable : assert property (
    @(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=>
        (!out_valid || ((out_data == $past(out_data)) && (out_wrap == $past(out_wrap))))
  );

  a_level_bound : assert property (
    @(posedge clk) disable iff (rst) (level <= DEPTH_L)
  );

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// tb_count_snapshot_fifo
//
// Directed bench for count_snapshot_fifo (DEPTH=4, CW=8). Inputs are driven
// 1 ns after each rising edge and outputs are sampled there as well, well
// away from the active edge.
module tb_count_snapshot_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic                   clk;
  logic                   rst;
  logic [CW-1:0]          count_in;
  logic                   trig;
  logic                   ovf_clr;
  logic                   out_ready;
  logic                   out_valid;
  logic [CW-1:0]          out_data;
  logic                   out_wrap;
  logic [$clog2(DEPTH):0] level;
  logic                   full;
  logic                   empty;
  logic                   overflow;

  int total_checks;
  int bad_checks;

  count_snapshot_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .trig     (trig),
    .ovf_clr  (ovf_clr),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_wrap (out_wrap),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one set of inputs, let one rising edge pass, return 1 ns after it.
  task automatic applyStimulus(input logic [CW-1:0] cnt, input logic t,
                               input logic clr, input logic rdy);
    count_in  = cnt;
    trig      = t;
    ovf_clr   = clr;
    out_ready = rdy;
    @(posedge clk);
    #1;
    trig      = 1'b0;
    ovf_clr   = 1'b0;
    out_ready = 1'b0;
  endtask

  // Pop the head while checking its data and wrap flag first.
  task automatic popCheck(input string tag, input logic [CW-1:0] exp_data,
                          input logic exp_wrap);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"},  32'(out_data),  32'(exp_data));
    checkOutput({tag, "_wrap"},  32'(out_wrap),  32'(exp_wrap));
    applyStimulus(count_in, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    count_in     = 8'h00;
    trig         = 1'b0;
    ovf_clr      = 1'b0;
    out_ready    = 1'b0;
    rst          = 1'b1;

    // Reset state, with a trigger present that must be ignored.
    #1;
    count_in = 8'h77;
    trig     = 1'b1;
    @(posedge clk);
    #1;
    trig     = 1'b0;
    count_in = 8'h00;
    checkOutput("rst_level",    32'(level),     32'd0);
    checkOutput("rst_empty",    32'(empty),     32'd1);
    checkOutput("rst_full",     32'(full),      32'd0);
    checkOutput("rst_valid",    32'(out_valid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow),  32'd0);
    checkOutput("rst_data",     32'(out_data),  32'd0);
    checkOutput("rst_wrap",     32'(out_wrap),  32'd0);
    rst = 1'b0;

    // Basic capture.
    applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
    checkOutput("cap_valid", 32'(out_valid), 32'd1);
    checkOutput("cap_data",  32'(out_data),  32'h12);
    checkOutput("cap_wrap",  32'(out_wrap),  32'd0);
    checkOutput("cap_level", 32'(level),     32'd1);
    applyStimulus(8'h13, 1'b0, 1'b0, 1'b1);
    checkOutput("cap_empty", 32'(empty),     32'd1);

    // Fill and overflow: fifth trigger is dropped.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(CW'(i), 1'b1, 1'b0, 1'b0);
    end
    checkOutput("fill_level",    32'(level),    32'd4);
    checkOutput("fill_full",     32'(full),     32'd1);
    checkOutput("fill_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      popCheck("fill_pop", CW'(i), 1'b0);
    end
    checkOutput("fill_drained", 32'(empty), 32'd1);

    // Overflow clear without a drop, then clear coinciding with a drop.
    applyStimulus(8'h20, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_overflow", 32'(overflow), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(CW'(8'h20 + i), 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(8'h25, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_drop_overflow", 32'(overflow), 32'd1);
    checkOutput("clr_drop_level",    32'(level),    32'd4);
    applyStimulus(8'h26, 1'b0, 1'b1, 1'b0);
    checkOutput("clr_again", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop: 0x21 leaves, 0x30 enters.
    applyStimulus(8'h30, 1'b1, 1'b0, 1'b1);
    checkOutput("pp_level",    32'(level),    32'd4);
    checkOutput("pp_overflow", 32'(overflow), 32'd0);
    popCheck("pp_pop0", 8'h22, 1'b0);
    popCheck("pp_pop1", 8'h23, 1'b0);
    popCheck("pp_pop2", 8'h24, 1'b0);
    popCheck("pp_pop3", 8'h30, 1'b0);
    checkOutput("pp_empty", 32'(empty), 32'd1);

    // Wrap detection.
    applyStimulus(8'hFE, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_level", 32'(level), 32'd3);
    popCheck("wrap_after", 8'h01, 1'b1);
    popCheck("wrap_none",  8'h03, 1'b0);
    popCheck("wrap_edge",  8'h00, 1'b1);

    // Asynchronous reset mid-stream with three entries stored.
    applyStimulus(8'h50, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h51, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h52, 1'b1, 1'b0, 1'b0);
    checkOutput("ar_pre_level", 32'(level), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_empty", 32'(empty),     32'd1);
    checkOutput("ar_level", 32'(level),     32'd0);
    checkOutput("ar_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_data",  32'(out_data),  32'd0);
    rst = 1'b0;
    applyStimulus(8'h3F, 1'b0, 1'b0, 1'b0);
    checkOutput("ar_idle_empty", 32'(empty), 32'd1);
    applyStimulus(8'h40, 1'b1, 1'b0, 1'b0);
    checkOutput("ar_post_level", 32'(level), 32'd1);
    popCheck("ar_post", 8'h40, 1'b0);
    checkOutput("ar_final_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
